ctrl_unit: RTL and testbench

//  Control-unit FSM for the 8-bit accumulator processor; the decision-making end of the datapath control/status interface.

---
 rtl/ctrl_unit.sv | 165 ++++++++++++++++
 tb/tb_ctrl_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// ctrl_unit: fetch/decode/execute control FSM for the 8-bit accumulator processor.
// Optional build macro CU_INPUT_WAIT_EN: INPUT stalls until the operator pulses Enter.
module ctrl_unit #(
  parameter logic [1:0] ASEL_ADDSUB = 2'd0,
  parameter logic [1:0] ASEL_INPUT  = 2'd1,
  parameter logic [1:0] ASEL_RAM    = 2'd2,
  parameter int         CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       IR,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             Enter,
  output logic             IRload,
  output logic             JMPmux,
  output logic             PCload,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             Sub,
  output logic [1:0]       Asel,
  output logic             Halt,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Icount
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   input_done;
  logic   exec_done;

`ifdef CU_INPUT_WAIT_EN
  assign input_done = Enter;
`else
  // Enter has no effect in this build; OR-ing keeps the port referenced.
  assign input_done = Enter | 1'b1;
`endif

  always_comb begin
    state_next = S_START;
    exec_done  = 1'b0;
    case (state)
      S_START:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (IR)
          3'b000:  state_next = S_LOAD;
          3'b001:  state_next = S_STORE;
          3'b010:  state_next = S_ADD;
          3'b011:  state_next = S_SUB;
          3'b100:  state_next = S_INPUT;
          3'b101:  state_next = S_JZ;
          3'b110:  state_next = S_JPOS;
          default: state_next = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: begin
        state_next = S_FETCH;
        exec_done  = 1'b1;
      end
      S_INPUT: begin
        state_next = input_done ? S_FETCH : S_INPUT;
        exec_done  = input_done;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_START;
    endcase
  end

  // Icount retires an instruction on the edge that leaves its execute state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_START;
      Icount <= '0;
    end else begin
      state <= state_next;
      if (exec_done) begin
        Icount <= Icount + CNT_ONE;
      end
    end
  end

  // Reset overrides every strobe so a mid-instruction reset cannot write RAM or jump.
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ADDSUB;
    Halt    = 1'b0;
    case (state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Sub     = 1'b1;
        Aload   = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_INPUT;
        Aload = input_done;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
    if (Reset) begin
      IRload  = 1'b0;
      JMPmux  = 1'b0;
      PCload  = 1'b0;
      Meminst = 1'b0;
      MemWr   = 1'b0;
      Aload   = 1'b0;
      Sub     = 1'b0;
      Asel    = ASEL_ADDSUB;
      Halt    = 1'b0;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: drives instruction streams into ctrl_unit and compares every cycle
// against a per-instruction model of the fetch/decode/execute control words.
module tb_ctrl_unit;

  localparam int CNT_W = 8;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [2:0]       IR;
  logic             Aeq0;
  logic             Apos;
  logic             Enter;
  logic             IRload;
  logic             JMPmux;
  logic             PCload;
  logic             Meminst;
  logic             MemWr;
  logic             Aload;
  logic             Sub;
  logic [1:0]       Asel;
  logic             Halt;
  logic [3:0]       State;
  logic [CNT_W-1:0] Icount;

  int vectors     = 0;
  int miscompares = 0;
  int modelCount  = 0;

  ctrl_unit #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt),
    .State(State), .Icount(Icount)
  );

  always #5 Clock = ~Clock;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  // Packed as {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel,Halt,State}.
  function automatic logic [13:0] ctrlWord(input logic irl, jmp, pcl, mi, mw, al, sb,
                                           input logic [1:0] as, input logic hl,
                                           input logic [3:0] st);
    return {irl, jmp, pcl, mi, mw, al, sb, as, hl, st};
  endfunction

  function automatic logic [13:0] execWord(input logic [2:0] op, input logic aeq0,
                                           input logic apos, input logic loadA);
    case (op)
      3'd0:    return ctrlWord(0, 0, 0,    1, 0, 1,     0, 2'd2, 0, 4'd3);
      3'd1:    return ctrlWord(0, 0, 0,    1, 1, 0,     0, 2'd0, 0, 4'd4);
      3'd2:    return ctrlWord(0, 0, 0,    1, 0, 1,     0, 2'd0, 0, 4'd5);
      3'd3:    return ctrlWord(0, 0, 0,    1, 0, 1,     1, 2'd0, 0, 4'd6);
      3'd4:    return ctrlWord(0, 0, 0,    0, 0, loadA, 0, 2'd1, 0, 4'd7);
      3'd5:    return ctrlWord(0, 1, aeq0, 0, 0, 0,     0, 2'd0, 0, 4'd8);
      3'd6:    return ctrlWord(0, 1, apos, 0, 0, 0,     0, 2'd0, 0, 4'd9);
      default: return ctrlWord(0, 0, 0,    0, 0, 0,     0, 2'd0, 1, 4'd10);
    endcase
  endfunction

  function automatic logic [13:0] quietWord(input logic [3:0] st);
    return ctrlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, st);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [13:0] expWord);
    checkOutput({tag, " ctrl"},
                {18'd0, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State},
                {18'd0, expWord});
    checkOutput({tag, " icount"}, 32'(Icount), 32'(modelCount % (1 << CNT_W)));
  endtask

  task automatic applyStimulus(input logic [2:0] ir, input logic aeq0, input logic apos,
                               input logic enter, input logic rst);
    IR    = ir;
    Aeq0  = aeq0;
    Apos  = apos;
    Enter = enter;
    Reset = rst;
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // Enters at the START cycle, leaves positioned at the following FETCH cycle.
  task automatic checkStart(input string tag);
    applyStimulus(rop(), rbit(), rbit(), rbit(), 1'b0);
    #1 checkCycle(tag, quietWord(4'd0));
    nextCycle();
  endtask

  // Enters at a FETCH cycle; returns at the next FETCH cycle (or at the HALT cycle).
  task automatic runInstr(input logic [2:0] op, input logic aeq0, input logic apos,
                          input int stall, input logic resetInExec);
    logic enterVal;
    applyStimulus(rop(), rbit(), rbit(), rbit(), 1'b0);
    #1 checkCycle("fetch", ctrlWord(1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd1));
    nextCycle();
    applyStimulus(op, rbit(), rbit(), rbit(), 1'b0);
    #1 checkCycle("decode", ctrlWord(0, 0, 0, 1, 0, 0, 0, 2'd0, 0, 4'd2));
    nextCycle();
`ifdef CU_INPUT_WAIT_EN
    enterVal = 1'b1;
    if (op == 3'd4) begin
      for (int i = 0; i < stall; i++) begin
        applyStimulus(op, rbit(), rbit(), 1'b0, 1'b0);
        #1 checkCycle("input wait", execWord(3'd4, 1'b0, 1'b0, 1'b0));
        nextCycle();
      end
    end
`else
    enterVal = rbit();
`endif
    applyStimulus(op, aeq0, apos, enterVal, resetInExec);
    #1;
    if (resetInExec) begin
      checkCycle("exec under reset", quietWord(4'(op) + 4'd3));
      modelCount = 0;
      nextCycle();
      checkStart("start after reset");
    end else begin
      checkCycle("exec", execWord(op, aeq0, apos, 1'b1));
      if (op != 3'd7) begin
        modelCount++;
        nextCycle();
      end
    end
  endtask

  initial begin
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    #1 checkCycle("held reset", quietWord(4'd0));
    nextCycle();
    checkStart("start");

    // Directed coverage of each opcode and the jump conditions.
    runInstr(3'd0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("icount after load", 32'(Icount), 32'd1);
    runInstr(3'd5, 1'b1, 1'b0, 0, 1'b0);
    runInstr(3'd5, 1'b0, 1'b1, 0, 1'b0);
    runInstr(3'd6, 1'b0, 1'b1, 0, 1'b0);
    runInstr(3'd6, 1'b1, 1'b0, 0, 1'b0);
    runInstr(3'd1, 1'b0, 1'b0, 0, 1'b0);
    runInstr(3'd2, 1'b0, 1'b0, 0, 1'b0);
    runInstr(3'd3, 1'b1, 1'b1, 0, 1'b0);
    runInstr(3'd4, 1'b0, 1'b0, 5, 1'b0);
    runInstr(3'd4, 1'b0, 1'b0, 0, 1'b0);
    runInstr(3'd1, 1'b0, 1'b0, 0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      runInstr(3'($urandom_range(0, 6)), rbit(), rbit(), $urandom_range(0, 3),
               ($urandom_range(0, 19) == 0));
    end

    runInstr(3'd7, rbit(), rbit(), 0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      nextCycle();
      applyStimulus(rop(), rbit(), rbit(), rbit(), 1'b0);
      #1 checkCycle("halt hold", execWord(3'd7, 1'b0, 1'b0, 1'b0));
    end
    nextCycle();
    applyStimulus(rop(), rbit(), rbit(), rbit(), 1'b1);
    #1 checkCycle("halt reset", quietWord(4'd10));
    modelCount = 0;
    nextCycle();
    checkStart("start after halt");

    for (int n = 0; n < 256; n++) begin
      runInstr(3'd0, rbit(), rbit(), 0, 1'b0);
    end
    checkOutput("icount wrap", 32'(Icount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
